dac_thrsh_event_gen: RTL and testbench
======================================

// Module: dac_thrsh_event_gen
// PURPOSE
//  Downstream consumer of the DAC stage's threshold/window outputs. Once per sample period it
//  detects qualified rising threshold crossings, emits a fixed-length TTL pulse followed by a
//  refractory interval, counts events, and buffers 32-bit event timestamps in a FIFO for readout.
// PARAMETERS
//  TICK_STATE   170  main_state value on which inputs are sampled (one tick per sample period)
//  TICK_CHANNEL 0    channel value qualifying the tick
//  FIFO_DEPTH   16   timestamp FIFO entries (power of 2, >=2)
// PORTS
//  dataclk          in   1   system clock
//  reset            in   1   asynchronous, active-high reset
//  main_state       in   32  main sequencer state
//  channel          in   6   current SPI channel
//  timestamp        in   32  sample counter, captured on event
//  DAC_thrsh_out    in   1   threshold comparator output from DAC stage
//  DAC_fsm_inwin_out in  1   window-qualifier output from DAC stage
//  use_window       in   1   1: trigger = thrsh & inwin; 0: trigger = thrsh
//  event_en         in   1   enables detection; 0 forces IDLE
//  pulse_len        in   16  TTL high length in ticks (0 treated as 1)
//  refractory_len   in   16  dead time in ticks after pulse (0 = none)
//  clear_overflow   in   1   single-cycle clear of fifo_overflow
//  fifo_rd          in   1   pop head entry
//  ttl_out          out  1   TTL pulse output
//  event_count      out  16  accepted events, saturating at 16'hFFFF
//  fifo_dout        out  32  head entry (first-word fall-through)
//  fifo_empty       out  1   FIFO empty
//  fifo_full        out  1   FIFO full
//  fifo_overflow    out  1   sticky: event dropped because FIFO full
// BEHAVIOUR
//  - Reset: ttl_out=0, event_count=0, fifo_empty=1, fifo_full=0, fifo_overflow=0, fifo_dout=0,
//    state=IDLE, trig_prev=0, counter=0. Reset mid-operation aborts pulse/refractory immediately.
//  - tick = (main_state==TICK_STATE)&&(channel==TICK_CHANNEL); all trigger inputs sampled only on tick.
//  - trig = DAC_thrsh_out & (use_window ? DAC_fsm_inwin_out : 1). trig_prev updated on every
//    tick in every state (incl. IDLE, REFRACT). edge = tick & trig & ~trig_prev.
//  - FSM: IDLE -> ARMED on the first cycle with event_en=1.
//    ARMED: on edge -> PULSE; cnt <= max(pulse_len,1); push timestamp; event_count++ (saturating).
//    PULSE: ttl_out=1; each later tick cnt--; on tick with cnt==1 -> REFRACT (cnt<=refractory_len)
//      or ARMED if refractory_len==0.
//    REFRACT: ttl_out=0; edges ignored; each tick cnt--; on tick with cnt==1 -> ARMED.
//    Any state: event_en=0 -> IDLE next cycle, ttl_out=0; FIFO and count retained.
//  - Latency: edge tick in cycle N -> ttl_out=1 from cycle N+1; high for exactly max(pulse_len,1)
//    sample periods; falls in the cycle after the expiring tick.
//  - ttl_out is registered (glitch-free); pulse_len/refractory_len sampled only when loaded.
//  - FIFO: push on accepted event; if full, entry dropped, fifo_overflow<=1 (event_count still
//    increments, TTL still fires). fifo_rd while empty ignored. Push+pop same cycle when full:
//    both occur, no overflow. Push+pop when empty: push only. Pointers wrap modulo FIFO_DEPTH.
//  - fifo_overflow cleared by clear_overflow unless a drop occurs in the same cycle (set wins).
//  - fifo_dout = head entry when non-empty; holds last value when empty.
// TESTING (5-clock frame 99,100,135,170,205 repeated, channel=0, timestamp++ per frame)
//  1. pulse_len=3, refractory_len=2, thrsh 0->1 at ts=10 -> ttl_out high 15 clocks, event_count=1,
//     fifo_dout=10, fifo_empty=0.
//  2. Same config, thrsh toggles 1->0->1 during refractory -> no new event, event_count stays 1;
//     rising edge after refractory ends -> event_count=2.
//  3. use_window=1, thrsh rises with inwin=0 -> no event; inwin=1 on next rising edge -> event.
//  4. FIFO_DEPTH=4, 6 events, no reads -> fifo_full=1, fifo_overflow=1, event_count=6, reads
//     return first 4 timestamps in order then fifo_empty=1; clear_overflow -> fifo_overflow=0.
//  5. pulse_len=0, refractory_len=0 -> ttl_out high exactly 1 tick (5 clocks); edge on next tick
//     accepted.
//  6. reset asserted mid-PULSE (async, between clock edges) -> ttl_out=0 immediately,
//     event_count=0, fifo_empty=1; event_en=0 mid-pulse -> ttl_out=0 next cycle, FIFO retained.

Source files
------------

// File: rtl/dac_thrsh_event_gen.sv
// dac_thrsh_event_gen
//   Watches the DAC stage threshold/window outputs once per sample period (the "tick"),
//   turns each qualified rising crossing into a fixed-length TTL pulse followed by an
//   optional refractory interval, counts accepted events and queues their timestamps in a
//   first-word-fall-through FIFO for readout.
//
//   dataclk, reset          system clock, asynchronous active-high reset
//   main_state, channel     sequencer position; tick = (TICK_STATE, TICK_CHANNEL)
//   timestamp               sample counter captured into the FIFO on each accepted event
//   DAC_thrsh_out           threshold comparator result
//   DAC_fsm_inwin_out       window qualifier, used when use_window=1
//   event_en                0 holds the detector in IDLE
//   pulse_len               TTL high time in ticks (0 behaves as 1)
//   refractory_len          dead time in ticks after the pulse (0 = none)
//   clear_overflow, fifo_rd overflow clear and FIFO pop
//   ttl_out                 registered TTL pulse
//   event_count             accepted events, saturating
//   fifo_dout/empty/full    FIFO head and status; fifo_dout holds its last value when empty
//   fifo_overflow           sticky, set when an accepted event found the FIFO full
//
//   state   | meaning
//   IDLE    | detection disabled
//   ARMED   | waiting for a rising edge of the qualified trigger
//   PULSE   | ttl_out high, counting down pulse ticks
//   REFRACT | ttl_out low, edges ignored, counting down dead-time ticks
module dac_thrsh_event_gen #(
    parameter logic [31:0] TICK_STATE   = 32'd170,
    parameter logic [5:0]  TICK_CHANNEL = 6'd0,
    parameter int          FIFO_DEPTH   = 16
) (
    input  logic        dataclk,
    input  logic        reset,
    input  logic [31:0] main_state,
    input  logic [5:0]  channel,
    input  logic [31:0] timestamp,
    input  logic        DAC_thrsh_out,
    input  logic        DAC_fsm_inwin_out,
    input  logic        use_window,
    input  logic        event_en,
    input  logic [15:0] pulse_len,
    input  logic [15:0] refractory_len,
    input  logic        clear_overflow,
    input  logic        fifo_rd,
    output logic        ttl_out,
    output logic [15:0] event_count,
    output logic [31:0] fifo_dout,
    output logic        fifo_empty,
    output logic        fifo_full,
    output logic        fifo_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FILL_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] FILL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_PULSE   = 2'd2;
    localparam logic [1:0] S_REFRACT = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          trig_prev_q, trig_prev_d;
    logic          ttl_q, ttl_d;
    logic [15:0]   evt_cnt_q, evt_cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   dout_hold_q, dout_hold_d;
    logic [31:0]   fifo_mem_q [FIFO_DEPTH];

    logic tick, trig, rise, accept;
    logic empty, full, push, pop, drop;

    assign tick  = (main_state == TICK_STATE) && (channel == TICK_CHANNEL);
    assign trig  = DAC_thrsh_out & (use_window ? DAC_fsm_inwin_out : 1'b1);
    assign rise  = tick & trig & ~trig_prev_q;
    assign empty = (fill_q == '0);
    assign full  = (fill_q == FILL_FULL);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        trig_prev_d = trig_prev_q;
        accept      = 1'b0;

        if (tick) begin
            trig_prev_d = trig;
        end

        if (!event_en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_ARMED;
                S_ARMED: begin
                    if (rise) begin
                        accept  = 1'b1;
                        state_d = S_PULSE;
                        cnt_d   = (pulse_len == 16'd0) ? 16'd1 : pulse_len;
                    end
                end
                S_PULSE: begin
                    if (tick) begin
                        // <=1 rather than ==1 so a corrupted zero count cannot stall here
                        if (cnt_q <= 16'd1) begin
                            if (refractory_len == 16'd0) begin
                                state_d = S_ARMED;
                            end else begin
                                state_d = S_REFRACT;
                                cnt_d   = refractory_len;
                            end
                        end else begin
                            cnt_d = cnt_q - 16'd1;
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        if (cnt_q <= 16'd1) begin
                            state_d = S_ARMED;
                        end else begin
                            cnt_d = cnt_q - 16'd1;
                        end
                    end
                end
            endcase
        end

        // Output registered from the next state so the pulse rises the cycle after the edge tick.
        ttl_d = (state_d == S_PULSE);

        evt_cnt_d = evt_cnt_q;
        if (accept && (evt_cnt_q != 16'hFFFF)) begin
            evt_cnt_d = evt_cnt_q + 16'd1;
        end

        // A pop in the same cycle frees the slot, so a push into a full FIFO is not a drop.
        pop  = fifo_rd & ~empty;
        push = accept & (~full | pop);
        drop = accept & full & ~pop;

        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push, pop})
            2'b10:   fill_d = fill_q + FILL_ONE;
            2'b01:   fill_d = fill_q - FILL_ONE;
            default: fill_d = fill_q;
        endcase

        if (drop) begin
            ovf_d = 1'b1;
        end else if (clear_overflow) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        fifo_dout   = empty ? dout_hold_q : fifo_mem_q[rd_ptr_q];
        dout_hold_d = fifo_dout;
    end

    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            trig_prev_q <= 1'b0;
            ttl_q       <= 1'b0;
            evt_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            ovf_q       <= 1'b0;
            dout_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            trig_prev_q <= trig_prev_d;
            ttl_q       <= ttl_d;
            evt_cnt_q   <= evt_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            ovf_q       <= ovf_d;
            dout_hold_q <= dout_hold_d;
        end
    end

    // Storage needs no reset: entries are only visible once written.
    always_ff @(posedge dataclk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= timestamp;
        end
    end

    assign ttl_out       = ttl_q;
    assign event_count   = evt_cnt_q;
    assign fifo_empty    = empty;
    assign fifo_full     = full;
    assign fifo_overflow = ovf_q;

endmodule

// File: tb/tb_dac_thrsh_event_gen.sv
module tb_dac_thrsh_event_gen;

    localparam int DEPTH = 4;
    localparam logic [31:0] FRAME_MS [5] = '{32'd99, 32'd100, 32'd135, 32'd170, 32'd205};

    logic        dataclk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] main_state = 32'd0;
    logic [5:0]  channel = 6'd0;
    logic [31:0] timestamp = 32'd0;
    logic        DAC_thrsh_out = 1'b0;
    logic        DAC_fsm_inwin_out = 1'b0;
    logic        use_window = 1'b0;
    logic        event_en = 1'b0;
    logic [15:0] pulse_len = 16'd0;
    logic [15:0] refractory_len = 16'd0;
    logic        clear_overflow = 1'b0;
    logic        fifo_rd = 1'b0;
    logic        ttl_out;
    logic [15:0] event_count;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_overflow;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          ttl_hi_cnt = 0;
    logic [31:0] ts_cnt = 32'd0;
    logic [31:0] exp_q [$];
    int          exp_fill = 0;
    logic [15:0] exp_count = 16'd0;
    logic        exp_ovf = 1'b0;
    logic [31:0] last_pop = 32'd0;

    dac_thrsh_event_gen #(
        .TICK_STATE  (32'd170),
        .TICK_CHANNEL(6'd0),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .dataclk          (dataclk),
        .reset            (reset),
        .main_state       (main_state),
        .channel          (channel),
        .timestamp        (timestamp),
        .DAC_thrsh_out    (DAC_thrsh_out),
        .DAC_fsm_inwin_out(DAC_fsm_inwin_out),
        .use_window       (use_window),
        .event_en         (event_en),
        .pulse_len        (pulse_len),
        .refractory_len   (refractory_len),
        .clear_overflow   (clear_overflow),
        .fifo_rd          (fifo_rd),
        .ttl_out          (ttl_out),
        .event_count      (event_count),
        .fifo_dout        (fifo_dout),
        .fifo_empty       (fifo_empty),
        .fifo_full        (fifo_full),
        .fifo_overflow    (fifo_overflow)
    );

    always #5 dataclk = ~dataclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Samples ttl_out (value after the previous rising edge) then drives the next main_state.
    task automatic clk_step(input logic [31:0] ms);
        @(negedge dataclk);
        ttl_hi_cnt += int'(ttl_out);
        main_state = ms;
    endtask

    // One sample period; fifo_rd optionally asserted only on the tick cycle.
    task automatic frame(input logic thr, input logic win, input logic rd_on_tick);
        DAC_thrsh_out     = thr;
        DAC_fsm_inwin_out = win;
        timestamp         = ts_cnt;
        for (int i = 0; i < 5; i++) begin
            clk_step(FRAME_MS[i]);
            fifo_rd = (i == 3) ? rd_on_tick : 1'b0;
        end
        ts_cnt = ts_cnt + 32'd1;
    endtask

    // Scoreboard push for an event the stimulus is expected to produce.
    task automatic expect_event(input logic [31:0] ts);
        if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
        if (exp_fill < DEPTH) begin
            exp_q.push_back(ts);
            exp_fill++;
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_fill  = 0;
        exp_count = 16'd0;
        exp_ovf   = 1'b0;
    endtask

    task automatic test_reset();
        clk_step(32'd0);
        clk_step(32'd0);
        vec_cnt++; if (ttl_out !== 1'b0) begin err_cnt++; $display("FAIL reset_ttl: got %b expected 0", ttl_out); end
        vec_cnt++; if (event_count !== 16'd0) begin err_cnt++; $display("FAIL reset_count: got %0d expected 0", event_count); end
        vec_cnt++; if (fifo_empty !== 1'b1) begin err_cnt++; $display("FAIL reset_empty: got %b expected 1", fifo_empty); end
        vec_cnt++; if (fifo_full !== 1'b0) begin err_cnt++; $display("FAIL reset_full: got %b expected 0", fifo_full); end
        vec_cnt++; if (fifo_overflow !== 1'b0) begin err_cnt++; $display("FAIL reset_ovf: got %b expected 0", fifo_overflow); end
        vec_cnt++; if (fifo_dout !== 32'd0) begin err_cnt++; $display("FAIL reset_dout: got %0d expected 0", fifo_dout); end
        reset = 1'b0;
        model_reset();
        event_en = 1'b1;
    endtask

    task automatic test_pulse();
        pulse_len = 16'd3; refractory_len = 16'd2; use_window = 1'b0;
        repeat (10) frame(1'b0, 1'b0, 1'b0);
        ttl_hi_cnt = 0;
        expect_event(ts_cnt);
        repeat (4) frame(1'b1, 1'b0, 1'b0);
        vec_cnt++; if (ttl_hi_cnt != 15) begin err_cnt++; $display("FAIL pulse_width: got %0d clocks expected 15", ttl_hi_cnt); end
        vec_cnt++; if (event_count !== exp_count) begin err_cnt++; $display("FAIL pulse_count: got %0d expected %0d", event_count, exp_count); end
        vec_cnt++; if (fifo_empty !== 1'b0) begin err_cnt++; $display("FAIL pulse_empty: got %b expected 0", fifo_empty); end
        vec_cnt++; if (fifo_dout !== 32'd10) begin err_cnt++; $display("FAIL pulse_dout: got %0d expected 10", fifo_dout); end
    endtask

    task automatic test_refractory();
        ttl_hi_cnt = 0;
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0);
        vec_cnt++; if (event_count !== exp_count) begin err_cnt++; $display("FAIL refract_ignore: got %0d expected %0d", event_count, exp_count); end
        vec_cnt++; if (ttl_hi_cnt != 0) begin err_cnt++; $display("FAIL refract_ttl: got %0d clocks expected 0", ttl_hi_cnt); end
        frame(1'b0, 1'b0, 1'b0);
        expect_event(ts_cnt);
        repeat (4) frame(1'b1, 1'b0, 1'b0);
        vec_cnt++; if (event_count !== exp_count) begin err_cnt++; $display("FAIL refract_rearm: got %0d expected %0d", event_count, exp_count); end
        vec_cnt++; if (ttl_hi_cnt != 15) begin err_cnt++; $display("FAIL refract_pulse: got %0d clocks expected 15", ttl_hi_cnt); end
        repeat (2) frame(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_window();
        use_window = 1'b1;
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0);
        vec_cnt++; if (event_count !== exp_count) begin err_cnt++; $display("FAIL window_block: got %0d expected %0d", event_count, exp_count); end
        frame(1'b0, 1'b1, 1'b0);
        expect_event(ts_cnt);
        frame(1'b1, 1'b1, 1'b0);
        vec_cnt++; if (event_count !== exp_count) begin err_cnt++; $display("FAIL window_pass: got %0d expected %0d", event_count, exp_count); end
        repeat (5) frame(1'b1, 1'b1, 1'b0);
        use_window = 1'b0;
    endtask

    task automatic test_pulse_min();
        pulse_len = 16'd0; refractory_len = 16'd0;
        frame(1'b0, 1'b0, 1'b0);
        ttl_hi_cnt = 0;
        expect_event(ts_cnt);
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        vec_cnt++; if (ttl_hi_cnt != 5) begin err_cnt++; $display("FAIL min_width: got %0d clocks expected 5", ttl_hi_cnt); end
        expect_event(ts_cnt);
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        vec_cnt++; if (ttl_hi_cnt != 10) begin err_cnt++; $display("FAIL min_back_to_back: got %0d clocks expected 10", ttl_hi_cnt); end
        vec_cnt++; if (event_count !== exp_count) begin err_cnt++; $display("FAIL min_count: got %0d expected %0d", event_count, exp_count); end
        vec_cnt++; if (fifo_overflow !== exp_ovf) begin err_cnt++; $display("FAIL min_ovf: got %b expected %b", fifo_overflow, exp_ovf); end
        vec_cnt++; if (fifo_full !== (exp_fill == DEPTH)) begin err_cnt++; $display("FAIL min_full: got %b expected %b", fifo_full, exp_fill == DEPTH); end
    endtask

    task automatic test_fifo_overflow();
        clk_step(32'd99);
        reset = 1'b1;
        clk_step(32'd99);
        reset = 1'b0;
        model_reset();
        pulse_len = 16'd1; refractory_len = 16'd0;
        frame(1'b0, 1'b0, 1'b0);
        repeat (6) begin
            expect_event(ts_cnt);
            frame(1'b1, 1'b0, 1'b0);
            frame(1'b0, 1'b0, 1'b0);
        end
        vec_cnt++; if (fifo_full !== 1'b1) begin err_cnt++; $display("FAIL ovf_full: got %b expected 1", fifo_full); end
        vec_cnt++; if (fifo_overflow !== exp_ovf) begin err_cnt++; $display("FAIL ovf_flag: got %b expected %b", fifo_overflow, exp_ovf); end
        vec_cnt++; if (event_count !== exp_count) begin err_cnt++; $display("FAIL ovf_count: got %0d expected %0d", event_count, exp_count); end
        for (int i = 0; i < DEPTH; i++) begin
            clk_step(32'd99);
            vec_cnt++;
            if (exp_q.size() == 0) begin
                err_cnt++; $display("FAIL ovf_read%0d: got %0d expected no entry", i, fifo_dout);
            end else begin
                last_pop = exp_q.pop_front();
                exp_fill--;
                if (fifo_dout !== last_pop) begin err_cnt++; $display("FAIL ovf_read%0d: got %0d expected %0d", i, fifo_dout, last_pop); end
            end
            fifo_rd = 1'b1;
        end
        clk_step(32'd99);
        fifo_rd = 1'b0;
        vec_cnt++; if (fifo_empty !== 1'b1) begin err_cnt++; $display("FAIL ovf_drained: got %b expected 1", fifo_empty); end
        vec_cnt++; if (fifo_dout !== last_pop) begin err_cnt++; $display("FAIL ovf_hold: got %0d expected %0d", fifo_dout, last_pop); end
        fifo_rd = 1'b1;
        clk_step(32'd99);
        fifo_rd = 1'b0;
        clk_step(32'd99);
        vec_cnt++; if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin err_cnt++; $display("FAIL empty_read: got empty=%b full=%b expected empty=1 full=0", fifo_empty, fifo_full); end
        clear_overflow = 1'b1;
        clk_step(32'd99);
        clear_overflow = 1'b0;
        exp_ovf = 1'b0;
        vec_cnt++; if (fifo_overflow !== exp_ovf) begin err_cnt++; $display("FAIL ovf_clear: got %b expected %b", fifo_overflow, exp_ovf); end
    endtask

    task automatic test_back_to_back();
        repeat (DEPTH) begin
            expect_event(ts_cnt);
            frame(1'b1, 1'b0, 1'b0);
            frame(1'b0, 1'b0, 1'b0);
        end
        vec_cnt++; if (fifo_full !== 1'b1) begin err_cnt++; $display("FAIL b2b_full: got %b expected 1", fifo_full); end
        vec_cnt++;
        if (exp_q.size() == 0) begin
            err_cnt++; $display("FAIL b2b_head: got %0d expected an entry", fifo_dout);
        end else begin
            last_pop = exp_q.pop_front();
            if (fifo_dout !== last_pop) begin err_cnt++; $display("FAIL b2b_head: got %0d expected %0d", fifo_dout, last_pop); end
        end
        // push and pop on the same tick with the FIFO full: both happen, fill unchanged
        exp_count = exp_count + 16'd1;
        exp_q.push_back(ts_cnt);
        frame(1'b1, 1'b0, 1'b1);
        frame(1'b0, 1'b0, 1'b0);
        vec_cnt++; if (fifo_overflow !== 1'b0) begin err_cnt++; $display("FAIL b2b_ovf: got %b expected 0", fifo_overflow); end
        vec_cnt++; if (fifo_full !== 1'b1) begin err_cnt++; $display("FAIL b2b_still_full: got %b expected 1", fifo_full); end
        vec_cnt++; if (event_count !== exp_count) begin err_cnt++; $display("FAIL b2b_count: got %0d expected %0d", event_count, exp_count); end
        for (int i = 0; i < DEPTH; i++) begin
            clk_step(32'd99);
            vec_cnt++;
            if (exp_q.size() == 0) begin
                err_cnt++; $display("FAIL b2b_read%0d: got %0d expected no entry", i, fifo_dout);
            end else begin
                last_pop = exp_q.pop_front();
                if (fifo_dout !== last_pop) begin err_cnt++; $display("FAIL b2b_read%0d: got %0d expected %0d", i, fifo_dout, last_pop); end
            end
            fifo_rd = 1'b1;
        end
        clk_step(32'd99);
        fifo_rd = 1'b0;
        exp_fill = 0;
        vec_cnt++; if (fifo_empty !== 1'b1) begin err_cnt++; $display("FAIL b2b_empty: got %b expected 1", fifo_empty); end
    endtask

    task automatic test_abort();
        pulse_len = 16'd3; refractory_len = 16'd2;
        frame(1'b0, 1'b0, 1'b0);
        expect_event(ts_cnt);
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0);
        vec_cnt++; if (ttl_out !== 1'b1) begin err_cnt++; $display("FAIL abort_pre: got %b expected 1", ttl_out); end
        #2 reset = 1'b1;
        #1;
        model_reset();
        vec_cnt++; if (ttl_out !== 1'b0) begin err_cnt++; $display("FAIL async_ttl: got %b expected 0", ttl_out); end
        vec_cnt++; if (event_count !== exp_count) begin err_cnt++; $display("FAIL async_count: got %0d expected %0d", event_count, exp_count); end
        vec_cnt++; if (fifo_empty !== 1'b1) begin err_cnt++; $display("FAIL async_empty: got %b expected 1", fifo_empty); end
        clk_step(32'd99);
        clk_step(32'd99);
        reset = 1'b0;
        frame(1'b0, 1'b0, 1'b0);
        expect_event(ts_cnt);
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0);
        vec_cnt++; if (ttl_out !== 1'b1) begin err_cnt++; $display("FAIL disable_pre: got %b expected 1", ttl_out); end
        event_en = 1'b0;
        clk_step(32'd99);
        vec_cnt++; if (ttl_out !== 1'b0) begin err_cnt++; $display("FAIL disable_ttl: got %b expected 0", ttl_out); end
        vec_cnt++; if (event_count !== exp_count) begin err_cnt++; $display("FAIL disable_count: got %0d expected %0d", event_count, exp_count); end
        vec_cnt++;
        if (exp_q.size() == 0 || fifo_empty !== 1'b0 || fifo_dout !== exp_q[0]) begin
            err_cnt++; $display("FAIL disable_fifo: got empty=%b dout=%0d expected retained entry", fifo_empty, fifo_dout);
        end
        event_en = 1'b1;
        clk_step(32'd99);
    endtask

    initial begin
        test_reset();
        test_pulse();
        test_refractory();
        test_window();
        test_pulse_min();
        test_fifo_overflow();
        test_back_to_back();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
